// File: rtl/if_id_buf.sv
// IF/ID pipeline buffer: a 2-entry FIFO of {pc, inst} between fetch and decode.
// Optional accepted-fetch counter enabled by defining IF_ID_PERF_CNT_EN.
module if_id_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic        if_ce,
  input  logic [31:0] if_inst,
  input  logic        flush,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        stall_req
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  logic [63:0] mem_q [2];
  logic [63:0] mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        push, pop;

  // A full buffer still accepts a fetch when the head leaves in the same cycle.
  assign stall_req = (count_q == 2'd2) && !id_ready;
  assign id_valid  = (count_q != 2'd0);
  assign pop       = id_valid && id_ready;
  assign push      = if_ce && !stall_req && !flush;
  assign id_pc     = id_valid ? mem_q[rd_ptr_q][63:32] : 32'h0;
  assign id_inst   = id_valid ? mem_q[rd_ptr_q][31:0]  : 32'h0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_comb begin
        mem_d[gi] = mem_q[gi];
        if (push && (wr_ptr_q == gi[0])) mem_d[gi] = {if_pc, if_inst};
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) mem_q[gi] <= 64'h0;
        else      mem_q[gi] <= mem_d[gi];
      end
    end
  endgenerate

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (push) fetch_cnt_d = fetch_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fetch_cnt_q <= 32'h0;
    else      fetch_cnt_q <= fetch_cnt_d;
  end

  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: doc/if_id_buf.md
IF_ID_BUF -- requirements
Module: if_id_buf

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset; rst=0 clears all state immediately.
REQ-004 if_pc  input  32  fetch address from the PC stage.
REQ-005 if_ce  input  1  fetch-valid from the PC stage; 1 = if_pc/if_inst form a valid fetch this cycle.
REQ-006 if_inst  input  32  instruction word read combinationally from instruction memory at if_pc.
REQ-007 flush  input  1  discards all buffered fetches (branch/exception redirect).
REQ-008 id_ready  input  1  decode stage accepts the head entry this cycle.
REQ-009 id_valid  output  1  head entry valid.
REQ-010 id_pc  output  32  PC of the head entry.
REQ-011 id_inst  output  32  instruction of the head entry.
REQ-012 stall_req  output  1  buffer cannot accept a fetch this cycle; PC stage holds.
REQ-013 fetch_cnt  output  32  accepted-fetch count; present only with IF_ID_PERF_CNT_EN.

Function
REQ-014 Storage SHALL be a 2-entry FIFO of {pc[31:0], inst[31:0]}, 1-bit rd/wr pointers, 2-bit occupancy count (0..2).
REQ-015 pop = id_valid & id_ready; push = if_ce & ~stall_req & ~flush.
REQ-016 stall_req SHALL be combinational: 1 iff count==2 and id_ready==0.
REQ-017 A fetch with if_ce=1 while stall_req=1 SHALL be dropped; the PC stage is responsible for holding.
REQ-018 Push SHALL write {if_pc, if_inst} at wr pointer on the clock edge, then increment wr pointer (mod 2).
REQ-019 Pop SHALL increment rd pointer (mod 2) on the clock edge.
REQ-020 Simultaneous push and pop SHALL leave count unchanged, including at count==2 (full pass-through) and count==1.
REQ-021 Push into empty buffer: id_valid=1 one cycle after the push edge (latency 1); no combinational if_*->id_* path.
REQ-022 id_valid = (count!=0); id_pc/id_inst SHALL show the rd-pointer entry when valid and 32'h0 when empty.
REQ-023 Pop with count==0 SHALL be impossible (id_valid=0) and count SHALL never underflow or exceed 2.
REQ-024 flush=1 SHALL, at the next edge, set count=0 and both pointers=0, with priority over any push/pop that cycle; id_valid=0 the following cycle.
REQ-025 Entry order SHALL be strictly FIFO; no entry reordered or duplicated.

Reset
REQ-026 rst=0 SHALL asynchronously force count=0, pointers=0, all storage entries=0, fetch_cnt=0.
REQ-027 During and directly after reset: id_valid=0, id_pc=0, id_inst=0, stall_req=0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered entries; no pop is reported for them.

Configuration
REQ-029 With IF_ID_PERF_CNT_EN defined, fetch_cnt SHALL increment by 1 on each push edge, wrap 32'hFFFFFFFF->0, be unaffected by flush, and clear only on reset.
REQ-030 Without IF_ID_PERF_CNT_EN, the fetch_cnt port and counter register SHALL not exist; all other behaviour identical.

Verification
REQ-031 Reset release, if_ce=1, if_pc=0,4,8 with inst A,B,C, id_ready=1 -> id_valid from cycle 2, id_pc 0,4,8 / id_inst A,B,C in order, stall_req always 0.
REQ-032 id_ready=0, push pc 0x10,0x14 -> count 2, stall_req=1, third fetch 0x18 dropped; id_ready=1 -> 0x10 then 0x14 out, 0x18 never appears.
REQ-033 count==2, id_ready=1, if_ce=1 pc 0x20 -> stall_req=0, 0x20 accepted, head advances, count stays 2.
REQ-034 count==2, flush=1 with if_ce=1 and id_ready=1 same cycle -> next cycle id_valid=0, id_pc=0, count 0; following fetch 0x40 appears as head with latency 1.
REQ-035 rst=0 asserted between clock edges with 1 entry held -> id_valid drops to 0 immediately without a clock edge; outputs 0.
REQ-036 IF_ID_PERF_CNT_EN defined, fetch_cnt preloaded by 0xFFFFFFFF pushes (or forced) then one push -> fetch_cnt=0; flush leaves it unchanged.
